// File: rtl/panel_key_encoder.sv
// Front-panel key/switch encoder: synchronises and debounces the raw pushbuttons and slide
// switches, turns them into counter control levels (hold, count_down, mode, fast) and reports
// each change as a one-cycle command on cmd_valid/cmd_code.
// Optional feature: define LONG_PRESS_EN to add the key_start long-press clear (clr_pulse, code 5).
module panel_key_encoder #(
  parameter int unsigned DEB_CYCLES  = 240000,
  parameter int unsigned LONG_CYCLES = 12000000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_dir,
  input  logic [1:0] sw_mode,
  input  logic       sw_fast,
  output logic       hold,
  output logic       count_down,
  output logic [1:0] mode,
  output logic       fast,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       clr_pulse
);

  // Bit order of the input vector: 0 key_start, 1 key_dir, 3:2 sw_mode, 4 sw_fast.
  localparam int unsigned NB = 5;
  // Keys idle released (1), switches idle at 0.
  localparam logic [NB-1:0] RST_VAL = 5'b00011;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    stable_q, stable_d;
  logic [NB-1:0]    prev_q;
  logic [CNT_W-1:0] deb_cnt_q [NB];
  logic [CNT_W-1:0] deb_cnt_d [NB];

  logic press_start, release_start, press_dir, mode_chg, fast_chg;
  logic ev_hold, ev_clear;
  logic hold_q, hold_d;
  logic down_q;
  logic [4:0] pend_q, pend_d, pend_all, grant;
  logic       cmd_valid_q;
  logic [2:0] cmd_code_q, code_d;

  assign raw = {sw_fast, sw_mode, key_dir, key_start};

  // Two-flop synchroniser for every raw pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: accept the synced value after DEB_CYCLES consecutive differing clocks.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state; prev_q lags stable_q by one clock and doubles as the switch outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= RST_VAL;
      prev_q   <= RST_VAL;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign press_start   = prev_q[0] & ~stable_q[0];
  assign release_start = ~prev_q[0] & stable_q[0];
  assign press_dir     = prev_q[1] & ~stable_q[1];
  assign mode_chg      = prev_q[3:2] != stable_q[3:2];
  assign fast_chg      = prev_q[4] != stable_q[4];

`ifdef LONG_PRESS_EN
  typedef enum logic [1:0] {StIdle, StDown, StLong} state_e;
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
  logic             clr_q, clr_d;

  // key_start FSM: short press toggles hold on release, long press requests a clear.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lp_cnt_d = '0;
    ev_hold  = 1'b0;
    ev_clear = 1'b0;
    clr_d    = 1'b0;
    case (state_q)
      StIdle: if (press_start) state_d = StDown;
      StDown: begin
        if (release_start) begin
          state_d = StIdle;
          hold_d  = ~hold_q;
          ev_hold = 1'b1;
        end else if (lp_cnt_q == LONG_MAX) begin
          state_d  = StLong;
          hold_d   = 1'b0;
          clr_d    = 1'b1;
          ev_clear = 1'b1;
        end else begin
          lp_cnt_d = lp_cnt_q + CNT_W'(1);
        end
      end
      StLong: if (release_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Long-press counter and clear strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lp_cnt_q <= '0;
      clr_q    <= 1'b0;
    end else begin
      lp_cnt_q <= lp_cnt_d;
      clr_q    <= clr_d;
    end
  end

  assign clr_pulse = clr_q;
`else
  typedef enum logic [0:0] {StIdle, StDown} state_e;

  state_e state_q, state_d;

  // key_start FSM: every press toggles hold; release just re-arms.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ev_hold = 1'b0;
    case (state_q)
      StIdle: begin
        if (press_start) begin
          state_d = StDown;
          hold_d  = ~hold_q;
          ev_hold = 1'b1;
        end
      end
      StDown: if (release_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ev_clear  = 1'b0;
  assign clr_pulse = 1'b0;
`endif

  // Command arbitration: merge new events into pending, emit the highest-priority one.
  always_comb begin
    pend_all = pend_q | {ev_clear, fast_chg, mode_chg, press_dir, ev_hold};
    grant    = '0;
    code_d   = 3'd0;
    if (pend_all[4]) begin
      grant[4] = 1'b1;
      code_d   = 3'd5;
    end else if (pend_all[0]) begin
      grant[0] = 1'b1;
      code_d   = 3'd1;
    end else if (pend_all[1]) begin
      grant[1] = 1'b1;
      code_d   = 3'd2;
    end else if (pend_all[2]) begin
      grant[2] = 1'b1;
      code_d   = 3'd3;
    end else if (pend_all[3]) begin
      grant[3] = 1'b1;
      code_d   = 3'd4;
    end
    pend_d = pend_all & ~grant;
  end

  // Control levels, FSM state and command outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hold_q      <= 1'b0;
      down_q      <= 1'b0;
      pend_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      down_q      <= down_q ^ press_dir;
      pend_q      <= pend_d;
      cmd_valid_q <= |pend_all;
      cmd_code_q  <= code_d;
    end
  end

  assign hold       = hold_q;
  assign count_down = down_q;
  assign mode       = prev_q[3:2];
  assign fast       = prev_q[4];
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;

endmodule

// File: tb/tb_panel_key_encoder.sv
// Bench for panel_key_encoder with short debounce/long-press thresholds: directed steps from the
// front-panel scenarios plus random key/switch bouncing, all checked against a window-based model.
module tb_panel_key_encoder;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam logic [4:0] RST_VAL = 5'b00011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_start = 1'b1;
  logic       key_dir = 1'b1;
  logic [1:0] sw_mode = 2'b00;
  logic       sw_fast = 1'b0;
  logic       hold, count_down, fast, cmd_valid, clr_pulse;
  logic [1:0] mode;
  logic [2:0] cmd_code;

  int n_cmp = 0;
  int n_bad = 0;

  panel_key_encoder #(
    .DEB_CYCLES (DEB),
    .LONG_CYCLES(LONG),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_dir   (key_dir),
    .sw_mode   (sw_mode),
    .sw_fast   (sw_fast),
    .hold      (hold),
    .count_down(count_down),
    .mode      (mode),
    .fast      (fast),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .clr_pulse (clr_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state: raw sample history, accepted values, outputs, pending commands.
  logic [4:0] hist [$];
  logic [4:0] stab, stab_prev;
  bit         m_hold, m_down, m_fast, m_valid, m_clr;
  logic [1:0] m_mode;
  logic [2:0] m_code;
  bit         pend [1:5];
  int         lp_state, lp_cnt;

  function automatic logic [9:0] dut_vec();
    return {hold, count_down, mode, fast, cmd_valid, cmd_code, clr_pulse};
  endfunction

  function automatic logic [9:0] model_vec();
    return {m_hold, m_down, m_mode, m_fast, m_valid, m_code, m_clr};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < DEB + 2; i++) hist.push_back(RST_VAL);
    stab = RST_VAL;
    stab_prev = RST_VAL;
    m_hold = 0; m_down = 0; m_fast = 0; m_valid = 0; m_clr = 0;
    m_mode = 2'b00; m_code = 3'd0;
    for (int c = 1; c <= 5; c++) pend[c] = 0;
    lp_state = 0;
    lp_cnt = 0;
  endtask

  // One clock of the model: react to the change accepted last clock, then re-evaluate acceptance.
  task automatic model_step();
    bit p_start, r_start, p_dir, c_mode, c_fast, ev_hold, ev_clr, all_diff;
    logic [4:0] raw, nxt, h;
    p_start = stab_prev[0] && !stab[0];
    r_start = !stab_prev[0] && stab[0];
    p_dir   = stab_prev[1] && !stab[1];
    c_mode  = stab_prev[3:2] != stab[3:2];
    c_fast  = stab_prev[4] != stab[4];
    m_mode  = stab[3:2];
    m_fast  = stab[4];
    ev_hold = 0;
    ev_clr  = 0;
    m_clr   = 0;
`ifdef LONG_PRESS_EN
    case (lp_state)
      0: if (p_start) begin lp_state = 1; lp_cnt = 0; end
      1: begin
        if (r_start) begin
          lp_state = 0; m_hold = !m_hold; ev_hold = 1;
        end else if (lp_cnt == LONG - 1) begin
          lp_state = 2; m_clr = 1; ev_clr = 1; m_hold = 0;
        end else begin
          lp_cnt++;
        end
      end
      default: if (r_start) lp_state = 0;
    endcase
`else
    if (p_start) begin m_hold = !m_hold; ev_hold = 1; end
`endif
    if (p_dir) m_down = !m_down;
    if (ev_clr) pend[5] = 1;
    if (ev_hold) pend[1] = 1;
    if (p_dir) pend[2] = 1;
    if (c_mode) pend[3] = 1;
    if (c_fast) pend[4] = 1;
    m_valid = 0;
    m_code = 3'd0;
    if (pend[5]) begin
      m_valid = 1; m_code = 3'd5; pend[5] = 0;
    end else begin
      for (int c = 1; c <= 4; c++) begin
        if (!m_valid && pend[c]) begin
          m_valid = 1; m_code = 3'(c); pend[c] = 0;
        end
      end
    end
    // A value is accepted once the two-clock-delayed raw input has disagreed for DEB clocks.
    raw = {sw_fast, sw_mode, key_dir, key_start};
    hist.push_front(raw);
    void'(hist.pop_back());
    nxt = stab;
    for (int b = 0; b < 5; b++) begin
      all_diff = 1;
      for (int j = 2; j <= DEB + 1; j++) begin
        h = hist[j];
        if (h[b] == stab[b]) all_diff = 0;
      end
      if (all_diff) nxt[b] = !stab[b];
    end
    stab_prev = stab;
    stab = nxt;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (rst) begin
      model_step();
      check(tag, dut_vec(), model_vec());
    end
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", dut_vec(), 10'd0);
    @(negedge clk);
    rst = 1'b1;

    // Idle: nothing ever reported.
    for (int i = 0; i < 100; i++) begin
      tick("idle");
      check("idle_no_cmd", {9'd0, cmd_valid}, 10'd0);
    end

    // key_dir glitch shorter than the debounce window.
    key_dir = 1'b0;
    ticks("dir_glitch", 2);
    key_dir = 1'b1;
    ticks("dir_glitch_wait", 12);
    check("dir_glitch_dropped", {9'd0, count_down}, 10'd0);

    // key_dir held: accepted, count_down and cmd 2 appear on clock 7.
    key_dir = 1'b0;
    ticks("dir_press", 6);
    check("dir_before_7", {8'd0, count_down, cmd_valid}, 10'd0);
    tick("dir_press");
    check("dir_at_7", {5'd0, count_down, cmd_valid, cmd_code}, {5'd0, 1'b1, 1'b1, 3'd2});
    ticks("dir_press", 3);
    key_dir = 1'b1;
    ticks("dir_release", 12);
    check("dir_release_no_tgl", {9'd0, count_down}, 10'd1);

    // Both switches change on the same clock.
    sw_mode = 2'b10;
    sw_fast = 1'b1;
    ticks("sw_chg", 7);
    check("sw_levels", {6'd0, mode, fast, cmd_valid}, {6'd0, 2'd2, 1'b1, 1'b1});
    check("sw_cmd3", {7'd0, cmd_code}, 10'd3);
    tick("sw_chg");
    check("sw_cmd4", {6'd0, cmd_valid, cmd_code}, {6'd0, 1'b1, 3'd4});
    tick("sw_chg");
    check("sw_drained", {9'd0, cmd_valid}, 10'd0);
    ticks("sw_wait", 4);

    // Both keys pressed together (count_down was 1, so it toggles back to 0).
    key_start = 1'b0;
    key_dir = 1'b0;
    ticks("both_press", 7);
`ifndef LONG_PRESS_EN
    check("both_levels", {8'd0, hold, count_down}, {8'd0, 1'b1, 1'b0});
    check("both_cmd1", {6'd0, cmd_valid, cmd_code}, {6'd0, 1'b1, 3'd1});
    tick("both_press");
    check("both_cmd2", {6'd0, cmd_valid, cmd_code}, {6'd0, 1'b1, 3'd2});
`endif
    key_start = 1'b1;
    key_dir = 1'b1;
    ticks("both_release", 14);

`ifdef LONG_PRESS_EN
    // Long press clears hold and emits exactly one clear strobe; its release does not toggle.
    begin
      int n_clr = 0;
      if (!hold) begin
        key_start = 1'b0;
        ticks("lp_short", 8);
        key_start = 1'b1;
        ticks("lp_short", 10);
      end
      check("lp_hold_set", {9'd0, hold}, 10'd1);
      key_start = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick("lp_long");
        if (clr_pulse) n_clr++;
      end
      check("lp_clr_once", 10'(n_clr), 10'd1);
      check("lp_hold_clr", {9'd0, hold}, 10'd0);
      key_start = 1'b1;
      ticks("lp_release", 12);
      check("lp_release_no_tgl", {9'd0, hold}, 10'd0);
    end
`endif

    // Reset during a held key_start.
    key_start = 1'b0;
    ticks("rst_press", 10);
    rst = 1'b0;
    #1;
    check("rst_async_outputs", dut_vec(), 10'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("rst_after");
      check("rst_no_cmd", {9'd0, cmd_valid}, 10'd0);
    end
    tick("rst_after");
`ifndef LONG_PRESS_EN
    check("rst_held_press", {6'd0, hold, cmd_valid, 2'd0}, {6'd0, 1'b1, 1'b1, 2'd0});
`endif
    key_start = 1'b1;
    ticks("rst_release", 12);

    // Random bouncing on every input, segments of random length.
    for (int s = 0; s < 80; s++) begin
      logic [4:0] r;
      r = 5'($urandom);
      key_start = r[0];
      key_dir   = r[1];
      sw_mode   = r[3:2];
      sw_fast   = r[4];
      ticks("random", int'($urandom_range(1, 10)));
    end
    ticks("random_settle", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
